hs32_fetch_queue: RTL and testbench
===================================

HS32_FETCH_QUEUE -- requirements
Module: hs32_fetch_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 32: opcode/data width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: entry count; power of two, >= 2.
REQ-003 SHALL have parameter AFULL, default DEPTH-1: almost-full threshold, 1..DEPTH.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port flush_i  input  1  discard all stored entries.
REQ-007 SHALL have port valid_i  input  1  upstream entry present.
REQ-008 SHALL have port ready_o  output  1  queue can accept.
REQ-009 SHALL have port op_i  input  WIDTH  upstream opcode.
REQ-010 SHALL have port banksel_i  input  1  register bank tag, stored with op_i.
REQ-011 SHALL have port valid_o  output  1  head entry present.
REQ-012 SHALL have port ready_i  input  1  downstream accepts.
REQ-013 SHALL have port data_o  output  WIDTH  head opcode.
REQ-014 SHALL have port banksel_o  output  1  head bank tag.
REQ-015 SHALL have port afull_o  output  1  occupancy >= AFULL.

Function
REQ-016 SHALL push when valid_i && ready_o at a rising edge; pop when valid_o && ready_i.
REQ-017 SHALL drive ready_o = !full && !flush_i; no pop-through when full (push with simultaneous pop while full not accepted).
REQ-018 SHALL have latency 1: entry pushed in cycle N visible on valid_o/data_o in cycle N+1 at earliest; no combinational input-to-output path.
REQ-019 SHALL deliver entries in strict push order, op_i and banksel_i paired unchanged.
REQ-020 SHALL keep occupancy constant on simultaneous push and pop (non-empty, non-full).
REQ-021 SHALL hold data_o/banksel_o stable while valid_o && !ready_i.
REQ-022 SHALL wrap read/write pointers modulo DEPTH; occupancy counter width clog2(DEPTH)+1.
REQ-023 SHALL on flush_i: ignore push and pop that cycle, occupancy 0 and valid_o=0 next cycle; pointers reset to 0.
REQ-024 SHALL ignore ready_i when empty; ignore valid_i when ready_o=0 (no state change).
REQ-025 SHALL compute afull_o from registered occupancy only.

Reset
REQ-026 SHALL on reset low, asynchronously: pointers=0, occupancy=0, valid_o=0, ready_o=1 (once flush_i low), afull_o=0, data_o=0, banksel_o=0.
REQ-027 SHALL discard any in-flight push/pop when reset asserts mid-transfer; first post-reset output is first post-reset push.

Configuration
REQ-028 SHALL, with HS32_FQ_LEVEL_EN defined, add output level_o (clog2(DEPTH)+1 bits) equal to registered occupancy.
REQ-029 SHALL, without HS32_FQ_LEVEL_EN, omit level_o entirely; all other behaviour identical.

Structure
REQ-030 SHALL take default WIDTH constant (HS32_OPW=32) and entry struct typedef {banksel, op} from shared package hs32_pkg.
REQ-031 SHALL place storage in one sub-module hs32_fq_mem (DEPTH x (WIDTH+1), one write port, one registered read port).
REQ-032 SHALL reject illegal DEPTH/AFULL via elaboration-time assertion.

Verification
REQ-033 SHALL cover: push 0x0020_0002, 0x0010_0001, 0x3031_2000, 0x0040_0004 with ready_i=1 -> same four out in order, each one cycle after push.
REQ-034 SHALL cover: DEPTH=4, ready_i=0, push 5 -> ready_o=0 after 4th, afull_o=1 after 3rd, 5th held upstream until one pop.
REQ-035 SHALL cover: occupancy 2, flush_i with valid_i=1 -> next cycle valid_o=0, level_o=0, flushed-cycle push lost.
REQ-036 SHALL cover: 10 continuous push/pop with DEPTH=4 -> pointer wrap, occupancy constant, no loss/duplication.
REQ-037 SHALL cover: reset asserted with 3 entries and ready_i=0 -> valid_o=0 immediately (asynchronous), first post-reset output = first post-reset push.
REQ-038 SHALL cover: banksel_i alternating 0,1,0,1 -> banksel_o matches per entry under random ready_i.

Source files
------------

// File: rtl/hs32_pkg.sv
// Shared HS32 definitions: default opcode width and the fetch-queue entry layout.
// No logic; constants, types and one sizing helper only.
// Imported by every fetch-queue file so entry field order stays in one place.
package hs32_pkg;

    localparam int HS32_OPW = 32;

    // One queued fetch: bank tag travels with its opcode, tag in the top bit.
    typedef struct packed {
        logic                banksel;
        logic [HS32_OPW-1:0] op;
    } hs32_entry_t;

    // Occupancy counter width: must be able to hold the value DEPTH itself.
    function automatic int hs32_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/hs32_fq_mem.sv
// Fetch-queue storage: DEPTH x DW array, one write port, one registered read port.
// Latency: read data appears one clock after rd_addr is presented (write-first bypass).
// Backpressure: none here; the caller gates writes and picks the next head address.
module hs32_fq_mem
    import hs32_pkg::*;
#(
    parameter int DW    = HS32_OPW + 1,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [DW-1:0]            i_wr_dat,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [DW-1:0]            o_rd_dat
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rd_dat;

    // Array write; contents need no reset because occupancy gates their use.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
    end

    // Registered head read; a same-cycle write to the head slot (empty queue) is forwarded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_dat <= '0;
        end else if (i_wr_en && (i_wr_addr == i_rd_addr)) begin
            r_rd_dat <= i_wr_dat;
        end else begin
            r_rd_dat <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/hs32_fetch_queue.sv
// In-order opcode/bank-tag fetch queue with flush; optional level_o under HS32_FQ_LEVEL_EN.
// Latency: 1 cycle push-to-head, all outputs registered except ready_o (gated by flush_i).
// Backpressure: ready_o drops when full or flushing; no pop-through while full.
module hs32_fetch_queue
    import hs32_pkg::*;
#(
    parameter int WIDTH = HS32_OPW,
    parameter int DEPTH = 4,
    parameter int AFULL = DEPTH - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] op_i,
    input  logic             banksel_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             banksel_o,
    output logic             afull_o
`ifdef HS32_FQ_LEVEL_EN
    ,
    output logic [hs32_cnt_w(DEPTH)-1:0] level_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = hs32_cnt_w(DEPTH);
    localparam int EW = WIDTH + 1;

    // Catch unusable geometries at elaboration rather than in silicon.
    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (AFULL < 1) || (AFULL > DEPTH)) begin : g_bad_cfg
            $error("hs32_fetch_queue: DEPTH must be a power of two >= 2 and AFULL within 1..DEPTH");
        end
    endgenerate

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] w_rd_ptr_nxt;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] w_wr_dat;
    logic [EW-1:0] w_rd_dat;

    assign w_full       = (r_cnt == CW'(DEPTH));
    assign ready_o      = !w_full && !flush_i;
    assign valid_o      = (r_cnt != '0);
    assign afull_o      = (r_cnt >= CW'(AFULL));
    assign w_push       = valid_i && ready_o;
    assign w_pop        = valid_o && ready_i && !flush_i;
    // Head address for the next cycle; the memory's read register follows it every clock.
    assign w_rd_ptr_nxt = flush_i ? '0 : (r_rd_ptr + AW'(w_pop));
    // Same field order as hs32_entry_t: bank tag on top of the opcode.
    assign w_wr_dat     = {banksel_i, op_i};
    assign {banksel_o, data_o} = w_rd_dat;

`ifdef HS32_FQ_LEVEL_EN
    assign level_o = r_cnt;
`endif

    // Pointer and occupancy bookkeeping; flush wins over any push or pop that cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= w_rd_ptr_nxt;
            r_cnt    <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    hs32_fq_mem #(
        .DW    (EW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_dat  (w_wr_dat),
        .i_rd_addr (w_rd_ptr_nxt),
        .o_rd_dat  (w_rd_dat)
    );

endmodule

// File: tb/tb_hs32_fetch_queue.sv
// Scoreboard bench for hs32_fetch_queue: directed pushes feed an expected queue,
// a negedge monitor compares head/flags against it and pops on each accepted output.
// Covers in-order delivery, full/afull backpressure, flush, pointer wrap, async reset, bank tags.
module tb_hs32_fetch_queue;
    import hs32_pkg::*;

    localparam int DEPTH = 4;
    localparam int AFULL = 3;
    localparam int CW    = 3;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        flush_i   = 1'b0;
    logic        valid_i   = 1'b0;
    logic        ready_i   = 1'b0;
    logic        banksel_i = 1'b0;
    logic [31:0] op_i      = '0;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] data_o;
    logic        banksel_o;
    logic        afull_o;
`ifdef HS32_FQ_LEVEL_EN
    logic [CW-1:0] level_o;
`endif

    always #5 clk = ~clk;

    hs32_fetch_queue #(.WIDTH(32), .DEPTH(DEPTH), .AFULL(AFULL)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush_i   (flush_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .op_i      (op_i),
        .banksel_i (banksel_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .data_o    (data_o),
        .banksel_o (banksel_o),
        .afull_o   (afull_o)
`ifdef HS32_FQ_LEVEL_EN
        ,
        .level_o   (level_o)
`endif
    );

    hs32_entry_t   sb[$];
    logic [CW-1:0] m_cnt = '0;
    int            total = 0;
    int            bad   = 0;
    logic          m_push;
    logic          m_pop;

    assign m_push = valid_i && (m_cnt < CW'(DEPTH)) && !flush_i;
    assign m_pop  = (m_cnt != '0) && ready_i && !flush_i;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference occupancy and expected-entry queue, updated at the same edge the DUT updates.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cnt <= '0;
            sb.delete();
        end else if (flush_i) begin
            m_cnt <= '0;
            sb.delete();
        end else begin
            if (m_push) sb.push_back({banksel_i, op_i});
            m_cnt <= m_cnt + CW'(m_push) - CW'(m_pop);
        end
    end

    // Monitor: check flags every cycle, compare the head whenever the DUT presents one.
    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_valid", 64'(valid_o), 64'(0));
            chk("rst_afull", 64'(afull_o), 64'(0));
            chk("rst_ready", 64'(ready_o), 64'(!flush_i));
            chk("rst_data",  64'({banksel_o, data_o}), 64'(0));
        end else begin
            chk("valid", 64'(valid_o), 64'(m_cnt != '0));
            chk("ready", 64'(ready_o), 64'((m_cnt < CW'(DEPTH)) && !flush_i));
            chk("afull", 64'(afull_o), 64'(m_cnt >= CW'(AFULL)));
`ifdef HS32_FQ_LEVEL_EN
            chk("level", 64'(level_o), 64'(m_cnt));
`endif
            if (valid_o && (sb.size() > 0)) begin
                chk("head", 64'({banksel_o, data_o}), 64'(sb[0]));
                if (ready_i && !flush_i) void'(sb.pop_front());
            end
        end
    end

    task automatic cyc(input logic v, input logic [31:0] op, input logic bs,
                       input logic rdy, input logic fl);
        valid_i   = v;
        op_i      = op;
        banksel_i = bs;
        ready_i   = rdy;
        flush_i   = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    endtask

    logic [31:0] ops_a [4] = '{32'h0020_0002, 32'h0010_0001, 32'h3031_2000, 32'h0040_0004};

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // In-order streaming with downstream always ready.
        for (int i = 0; i < 4; i++) cyc(1'b1, ops_a[i], 1'b0, 1'b1, 1'b0);
        drain(3);

        // Fill to full with no pops; fifth entry held until one pop frees a slot.
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'hA000_0001 + 32'(i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hA000_0005, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'hA000_0005, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'hA000_0005, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 32'hA000_0005, 1'b1, 1'b0, 1'b0);
        drain(6);

        // Flush at occupancy 2 with a push offered; that push must vanish.
        cyc(1'b1, 32'hB000_0001, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hB000_0002, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'hB000_0003, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 32'hB000_0004, 1'b1, 1'b1, 1'b0);
        drain(3);

        // Steady push+pop at occupancy 2 for ten cycles: pointers wrap twice.
        cyc(1'b1, 32'hC000_0000, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hC000_0001, 1'b1, 1'b0, 1'b0);
        for (int i = 2; i < 12; i++) cyc(1'b1, 32'hC000_0000 + 32'(i), 1'(i & 1), 1'b1, 1'b0);
        drain(4);

        // Asynchronous reset mid-cycle with three entries waiting.
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'hD000_0001 + 32'(i), 1'b0, 1'b0, 1'b0);
        valid_i = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("async_valid", 64'(valid_o), 64'(0));
        chk("async_afull", 64'(afull_o), 64'(0));
        chk("async_data",  64'({banksel_o, data_o}), 64'(0));
        @(posedge clk);
        #1 reset = 1'b1;
        cyc(1'b1, 32'hD000_0004, 1'b1, 1'b1, 1'b0);
        drain(3);

        // Alternating bank tags drained under random downstream readiness.
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'hE000_0000 + 32'(i), 1'(i & 1), 1'($urandom_range(0, 1)), 1'b0);
        for (int i = 0; i < 12; i++) cyc(1'b0, 32'h0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        drain(5);

        chk("sb_empty", 64'(sb.size()), 64'(0));
        chk("end_valid", 64'(valid_o), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
